// File: rtl/sha256_stream_core_if.sv
// Stream-in / digest-out bundle for sha256_stream_core.
// The host side uses the master modport; the core uses the slave modport.
interface sha256_stream_core_if #(
    parameter int DATA_BYTES = 4
);
    localparam int NB_W = $clog2(DATA_BYTES) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [8*DATA_BYTES-1:0] in_data;
    logic                    in_last;
    logic [NB_W-1:0]         in_nbytes;
    logic                    hash_valid;
    logic                    hash_ready;
    logic [7:0][31:0]        hash;
    logic                    busy;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, hash_ready,
        input  in_ready, hash_valid, hash, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, hash_ready,
        output in_ready, hash_valid, hash, busy
    );
endinterface

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256: packs beats into a 512-bit block, pads in hardware, one round per cycle.
// Optional SHA_SHA224_EN adds mode_224_i (SHA-224 IVs, hash[7] forced to 0).
module sha256_stream_core #(
    parameter int DATA_BYTES = 4,
    parameter int LEN_W      = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef SHA_SHA224_EN
    input  logic mode_224_i,
`endif
    sha256_stream_core_if.slave bus
);
    localparam int NB_W  = $clog2(DATA_BYTES) + 1;
    localparam int CNT_W = LEN_W - 3;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_ROUND, S_UPDATE, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [511:0]      blk_q, blk_d;      // byte k at [8*(63-k) +: 8]; word 0 is W_t during rounds
    logic [5:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [5:0]        t_q, t_d;
    logic [7:0][31:0]  h_q, h_d;
    logic [7:0][31:0]  v_q, v_d;          // working a..h, v[0] = a
    logic              last_q, last_d;
    logic              p80_q, p80_d;
    logic              fin_q, fin_d;
    logic              alive_q;

    logic              accept, first_beat, sel_in, sel224, fits;
    logic [NB_W-1:0]   nb;
    logic [5:0]        base, wr_pos;
    logic [8:0]        wr_lsb;
    logic [6:0]        fill;
    logic [31:0]       t1, t2, w16;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [7:0][31:0] iv_of(input logic s224);
        logic [7:0][31:0] r;
        if (s224) begin
            r[0] = 32'hc1059ed8; r[1] = 32'h367cd507; r[2] = 32'h3070dd17; r[3] = 32'hf70e5939;
            r[4] = 32'hffc00b31; r[5] = 32'h68581511; r[6] = 32'h64f98fa7; r[7] = 32'hbefa4fa4;
        end else begin
            r[0] = 32'h6a09e667; r[1] = 32'hbb67ae85; r[2] = 32'h3c6ef372; r[3] = 32'ha54ff53a;
            r[4] = 32'h510e527f; r[5] = 32'h9b05688c; r[6] = 32'h1f83d9ab; r[7] = 32'h5be0cd19;
        end
        return r;
    endfunction

`ifdef SHA_SHA224_EN
    logic mode224_q;
    assign sel_in = mode_224_i;
    assign sel224 = mode224_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         mode224_q <= 1'b0;
        else if (first_beat) mode224_q <= mode_224_i;
    end
`else
    assign sel_in = 1'b0;
    assign sel224 = 1'b0;
`endif

    assign bus.in_ready   = alive_q && (state_q == S_IDLE || state_q == S_LOAD);
    assign bus.hash_valid = (state_q == S_OUT);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.hash[6:0]  = h_q[6:0];
    assign bus.hash[7]    = sel224 ? 32'h0 : h_q[7];

    assign accept     = bus.in_valid && bus.in_ready;
    assign first_beat = accept && (state_q == S_IDLE);
    assign nb   = !bus.in_last ? NB_W'(DATA_BYTES)
                : (bus.in_nbytes > NB_W'(DATA_BYTES)) ? NB_W'(DATA_BYTES) : bus.in_nbytes;
    assign base = (state_q == S_IDLE) ? 6'd0 : idx_q;
    assign fill = {1'b0, base} + 7'(nb);
    assign fits = ({1'b0, idx_q} + {6'd0, ~p80_q}) <= 7'd56;

    assign t1  = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
               + K[t_q] + blk_q[511:480];
    assign t2  = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    assign w16 = ssig1(blk_q[63:32]) + blk_q[223:192] + ssig0(blk_q[479:448]) + blk_q[511:480];

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        len_d   = len_q;
        t_d     = t_q;
        h_d     = h_q;
        v_d     = v_q;
        last_d  = last_q;
        p80_d   = p80_q;
        fin_d   = fin_q;
        wr_pos  = '0;
        wr_lsb  = '0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (first_beat) begin
                        h_d   = iv_of(sel_in);
                        len_d = CNT_W'(nb);
                        p80_d = 1'b0;
                        fin_d = 1'b0;
                    end else begin
                        len_d = len_q + CNT_W'(nb);
                    end
                    for (int k = 0; k < DATA_BYTES; k++) begin
                        if (k < int'(nb)) begin
                            wr_pos = base + 6'(k);
                            wr_lsb = {~wr_pos, 3'b000};
                            blk_d[wr_lsb +: 8] = bus.in_data[8*(DATA_BYTES-1-k) +: 8];
                        end
                    end
                    last_d = bus.in_last;
                    // Non-final beats are full, so the last beat never straddles a block.
                    if (fill[6]) begin
                        idx_d   = 6'd0;
                        v_d     = h_d;
                        t_d     = 6'd0;
                        state_d = S_ROUND;
                    end else begin
                        idx_d   = fill[5:0];
                        state_d = bus.in_last ? S_PAD : S_LOAD;
                    end
                end
            end
            S_PAD: begin
                for (int k = 0; k < 64; k++) begin
                    if (k >= int'(idx_q))
                        blk_d[8*(63-k) +: 8] = (k == int'(idx_q) && !p80_q) ? 8'h80 : 8'h00;
                end
                if (fits) blk_d[63:0] = 64'({len_q, 3'b000});
                fin_d   = fits;
                p80_d   = 1'b1;
                idx_d   = 6'd0;
                v_d     = h_q;
                t_d     = 6'd0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                v_d[0] = t1 + t2;
                v_d[1] = v_q[0];
                v_d[2] = v_q[1];
                v_d[3] = v_q[2];
                v_d[4] = v_q[3] + t1;
                v_d[5] = v_q[4];
                v_d[6] = v_q[5];
                v_d[7] = v_q[6];
                blk_d  = {blk_q[479:0], w16};
                t_d    = t_q + 6'd1;
                if (t_q == 6'd63) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
                if (fin_q)       state_d = S_OUT;
                else if (last_q) state_d = S_PAD;
                else             state_d = S_LOAD;
            end
            S_OUT: begin
                if (bus.hash_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            t_q     <= '0;
            h_q     <= '0;
            last_q  <= 1'b0;
            p80_q   <= 1'b0;
            fin_q   <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            t_q     <= t_d;
            h_q     <= h_d;
            last_q  <= last_d;
            p80_q   <= p80_d;
            fin_q   <= fin_d;
            alive_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        blk_q <= blk_d;
        v_q   <= v_d;
    end
endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed + randomized bench for sha256_stream_core against a textbook SHA-256/224 model.
`timescale 1ns/1ps
module tb_sha256_stream_core;
    localparam int DB   = 4;
    localparam int NB_W = $clog2(DB) + 1;

    typedef logic [7:0][31:0] dig_t;
    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    sha256_stream_core_if #(.DATA_BYTES(DB)) ifc ();
`ifdef SHA_SHA224_EN
    logic mode_224;
`endif

    sha256_stream_core #(.DATA_BYTES(DB), .LEN_W(64)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
`ifdef SHA_SHA224_EN
        .mode_224_i (mode_224),
`endif
        .bus    (ifc)
    );

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook message digest: pad the byte queue, then compress block by block.
    function automatic dig_t sha_model(input bq_t msg, input bit is224);
        bq_t         m;
        logic [63:0] bl;
        logic [31:0] h [8];
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, x1, x2;
        dig_t        r;
        m  = msg;
        bl = 64'(msg.size()) * 64'd8;
        m.push_back(8'h80);
        while (m.size() % 64 != 56) m.push_back(8'h00);
        for (int i = 7; i >= 0; i--) m.push_back(bl[8*i +: 8]);
        if (is224) h = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                         32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
        else       h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int blk = 0; blk < m.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {m[64*blk+4*t], m[64*blk+4*t+1], m[64*blk+4*t+2], m[64*blk+4*t+3]};
            for (int t = 16; t < 64; t++)
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                x1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
                x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        for (int i = 0; i < 8; i++) r[i] = h[i];
        if (is224) r[7] = 32'h0;
        return r;
    endfunction

    function automatic dig_t mkd(input logic [255:0] x);
        dig_t r;
        for (int i = 0; i < 8; i++) r[i] = x[255-32*i -: 32];
        return r;
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t rnd_msg(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the final beat transfers.
    task automatic send_msg(input bq_t msg, input int gap_pct, input bit over_nb);
        int n, i, take, cnt;
        bit last;
        logic [8*DB-1:0] d;
        n = msg.size();
        i = 0;
        do begin
            take = (n - i > DB) ? DB : n - i;
            last = (n - i <= DB);
            d = '0;
            for (int k = 0; k < take; k++) d[8*(DB-1-k) +: 8] = msg[i+k];
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) @(negedge clk);
            ifc.in_valid  = 1'b1;
            ifc.in_data   = d;
            ifc.in_last   = last;
            ifc.in_nbytes = !last ? NB_W'($urandom_range(7)) : (over_nb ? NB_W'(7) : NB_W'(take));
            cnt = 0;
            while (ifc.in_ready !== 1'b1 && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 300) chk("in_ready_timeout", 256'(cnt), 256'(0));
            @(negedge clk);
            ifc.in_valid = 1'b0;
            ifc.in_last  = 1'b0;
            i += take;
        end while (i < n);
    endtask

    task automatic get_hash(input string tag, input dig_t exp, input int hold);
        int   cnt;
        bit   ok;
        dig_t snap;
        cnt = 0;
        while (ifc.hash_valid !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_valid"}, 256'(ifc.hash_valid), 256'(1));
        snap = ifc.hash;
        ok = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (ifc.hash !== snap || ifc.in_ready !== 1'b0 || ifc.hash_valid !== 1'b1) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_held"}, 256'(ok), 256'(1));
        chk({tag, "_digest"}, ifc.hash, exp);
        ifc.hash_ready = 1'b1;
        @(negedge clk);
        ifc.hash_ready = 1'b0;
        chk({tag, "_idle"}, {253'd0, ifc.hash_valid, ifc.busy, ifc.in_ready}, 256'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t  m;
        int   lens [6] = '{55, 56, 63, 64, 119, 120};
        int   n;
        rst_n          = 1'b0;
        ifc.in_valid   = 1'b0;
        ifc.in_data    = '0;
        ifc.in_last    = 1'b0;
        ifc.in_nbytes  = '0;
        ifc.hash_ready = 1'b0;
`ifdef SHA_SHA224_EN
        mode_224 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ifc.hash, 1'b0, ifc.in_ready, ifc.hash_valid, ifc.busy}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {254'd0, ifc.in_ready, ifc.busy}, 256'(2));

        send_msg(s2q("abc"), 0, 1'b0);
        chk("abc_busy", 256'(ifc.busy), 256'(1));
        get_hash("abc", mkd(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad), 0);

        send_msg(m, 0, 1'b0);
        get_hash("empty", mkd(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855), 0);

        send_msg(s2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 0, 1'b0);
        get_hash("two_block", mkd(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1), 0);

        send_msg(s2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 40, 1'b0);
        get_hash("gaps_hold", mkd(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1), 20);

        send_msg(s2q("wxyz"), 0, 1'b1);
        get_hash("nbytes_clamp", sha_model(s2q("wxyz"), 1'b0), 0);

        foreach (lens[j]) begin
            m = rnd_msg(lens[j]);
            send_msg(m, 0, 1'b0);
            get_hash($sformatf("len%0d", lens[j]), sha_model(m, 1'b0), 0);
        end

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 140);
            m = rnd_msg(n);
            send_msg(m, 30, 1'b0);
            get_hash($sformatf("rand%0d_len%0d", r, n), sha_model(m, 1'b0), $urandom_range(0, 5));
        end

        send_msg(s2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 0, 1'b0);
        repeat (31) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midround_reset", {ifc.hash, 1'b0, ifc.in_ready, ifc.hash_valid, ifc.busy}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_msg(s2q("abc"), 0, 1'b0);
        get_hash("abc_after_reset", mkd(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad), 0);

`ifdef SHA_SHA224_EN
        mode_224 = 1'b1;
        send_msg(s2q("abc"), 0, 1'b0);
        mode_224 = 1'b0;
        get_hash("abc224", mkd(256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000), 0);
        mode_224 = 1'b1;
        m = rnd_msg(70);
        send_msg(m, 20, 1'b0);
        mode_224 = 1'b0;
        get_hash("rand224", sha_model(m, 1'b1), 3);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
